systolic_n_body_linear: RTL and testbench

Parametrised successor to the fixed 2x2 systolic force array. It is a linear systolic array of `LANES` cells. Each cell holds one resident body; all `N_BODIES` bodies stream past the cells, and each cell accumulates the 1-D pairwise force on its resident body. It tiles an arbitrary body count into `N_BODIES/LANES` passes, with a load handshake on the input side and a back-pressured result stream on the output side. It sits between the body-state source and the Verlet integration stage as a ModelSim simulation model (`real` datapath, not synthesizable).

---
 rtl/systolic_n_body_pkg.sv | 34 +++
 rtl/systolic_n_body_lane_cell.sv | 75 +++++++
 rtl/systolic_n_body_linear.sv | 230 +++++++++++++++++++++++
 tb/tb_systolic_n_body_linear.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_n_body_pkg.sv
// Shared types and helpers for the linear systolic N-body force array.
//   EPS        : separation below which a pair contributes no force
//   state_t    : controller states
//   body_t     : buffered body {position, mass, valid}
//   pair_force : 1-D force on body i from body j, without G
package systolic_n_body_pkg;

  localparam real EPS = 1e-8;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_UNLOAD = 2'd3
  } state_t;

  typedef struct {
    real  q;
    real  m;
    logic valid;
  } body_t;

  // Coincident bodies (including self-pairs) contribute exactly zero.
  function automatic real pair_force(input real qi, input real mi,
                                     input real qj, input real mj);
    real d;
    real ad;
    d  = qj - qi;
    ad = (d < 0.0) ? -d : d;
    if (ad < EPS) return 0.0;
    return mi * mj * d / (ad * ad * ad);
  endfunction

endpackage

// File: rtl/systolic_n_body_lane_cell.sv
// One systolic cell: holds a resident body, accumulates the force on it from
// every valid streaming body, and forwards the streaming body one cycle later.
//   clk, rst_n     : clock, synchronous active-low reset
//   load_res       : capture the incoming body as the resident
//   clr_acc        : zero the accumulator
//   in_body_*      : streaming body from the previous cell (or the feed)
//   out_body_*     : registered copy of in_body_* for the next cell
//   acc            : accumulator value including this cycle's term
module systolic_n_body_lane_cell
  import systolic_n_body_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load_res,
  input  logic clr_acc,
  input  real  in_body_pos,
  input  real  in_body_mass,
  input  logic in_body_vld,
  output real  out_body_pos,
  output real  out_body_mass,
  output logic out_body_vld,
  output real  acc
);

  real  res_pos_q, res_pos_d;
  real  res_mass_q, res_mass_d;
  real  acc_q, acc_d;
  real  fwd_pos_q, fwd_pos_d;
  real  fwd_mass_q, fwd_mass_d;
  logic fwd_vld_q, fwd_vld_d;

  always_comb begin
    res_pos_d  = res_pos_q;
    res_mass_d = res_mass_q;
    acc_d      = acc_q;
    fwd_pos_d  = in_body_pos;
    fwd_mass_d = in_body_mass;
    fwd_vld_d  = in_body_vld;
    if (load_res) begin
      res_pos_d  = in_body_pos;
      res_mass_d = in_body_mass;
    end
    if (clr_acc) begin
      acc_d = 0.0;
    end else if (in_body_vld) begin
      acc_d = acc_q + pair_force(res_pos_q, res_mass_q, in_body_pos, in_body_mass);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_pos_q  <= 0.0;
      res_mass_q <= 0.0;
      acc_q      <= 0.0;
      fwd_pos_q  <= 0.0;
      fwd_mass_q <= 0.0;
      fwd_vld_q  <= 1'b0;
    end else begin
      res_pos_q  <= res_pos_d;
      res_mass_q <= res_mass_d;
      acc_q      <= acc_d;
      fwd_pos_q  <= fwd_pos_d;
      fwd_mass_q <= fwd_mass_d;
      fwd_vld_q  <= fwd_vld_d;
    end
  end

  // Exposing the next value lets the last cell's final term reach the
  // first output beat without an extra cycle.
  assign acc           = acc_d;
  assign out_body_pos  = fwd_pos_q;
  assign out_body_mass = fwd_mass_q;
  assign out_body_vld  = fwd_vld_q;

endmodule

// File: rtl/systolic_n_body_linear.sv
// Linear systolic array of LANES cells computing 1-D pairwise forces for
// N_BODIES bodies, tiled into N_BODIES/LANES passes.
//   clk, rst_n                   : clock, synchronous active-low reset
//   in_valid/in_ready/in_q/in_m  : body load handshake
//   out_valid/out_ready          : force result handshake
//   out_f/out_idx/out_last       : force, body index, last-beat flag
//   busy                         : high whenever not loading
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_LOAD   | accept N_BODIES bodies into the buffer
// ST_FILL   | shift this pass's resident bodies into the cells (LANES cyc)
// ST_STREAM | stream all bodies through the cells (N_BODIES+LANES-1 cyc)
// ST_UNLOAD | present the LANES accumulators under back-pressure
module systolic_n_body_linear
  import systolic_n_body_pkg::*;
#(
  parameter int N_BODIES = 8,
  parameter int LANES    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  real                         in_q,
  input  real                         in_m,
  output logic                        out_valid,
  input  logic                        out_ready,
  output real                         out_f,
  output logic [$clog2(N_BODIES)-1:0] out_idx,
  output logic                        out_last,
  output logic                        busy
);

  localparam int IW          = $clog2(N_BODIES);
  localparam int NPASS       = N_BODIES / LANES;
  localparam int PW          = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam int KW          = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SW          = $clog2(N_BODIES + LANES);
  localparam int STREAM_LAST = N_BODIES + LANES - 2;

  if ((N_BODIES < 2) || ((N_BODIES % LANES) != 0)) begin : g_bad_cfg
    $error("systolic_n_body_linear: N_BODIES must be >= 2 and a multiple of LANES");
  end

  state_t          state_q, state_d;
  logic [IW-1:0]   load_cnt_q, load_cnt_d;
  logic [PW-1:0]   pass_q, pass_d;
  logic [SW-1:0]   stream_cnt_q, stream_cnt_d;
  logic [KW-1:0]   unload_k_q, unload_k_d;
  logic            out_valid_q, out_valid_d;
  real             out_f_q, out_f_d;
  logic [IW-1:0]   out_idx_q, out_idx_d;
  logic            out_last_q, out_last_d;

  body_t           body_buf_q [N_BODIES];
  logic            buf_we;

  logic            load_res, clr_acc;
  real             chain_pos  [LANES];
  real             chain_mass [LANES];
  logic            chain_vld  [LANES];
  real             acc_w      [LANES];
  real             tail_pos_unused, tail_mass_unused;
  logic            tail_vld_unused;

  int              stream_idx, fill_idx;

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    pass_d       = pass_q;
    stream_cnt_d = stream_cnt_q;
    unload_k_d   = unload_k_q;
    out_valid_d  = out_valid_q;
    out_f_d      = out_f_q;
    out_idx_d    = out_idx_q;
    out_last_d   = out_last_q;
    buf_we       = 1'b0;
    load_res     = 1'b0;
    clr_acc      = 1'b0;
    chain_pos[0]  = 0.0;
    chain_mass[0] = 0.0;
    chain_vld[0]  = 1'b0;
    stream_idx = STREAM_LAST - int'(stream_cnt_q);
    // Fill feeds residents in reverse so cell k holds body pass*LANES+k
    // once the last fill beat has shifted through.
    fill_idx   = int'(pass_q) * LANES + (LANES - 1 - int'(unload_k_q));

    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          buf_we = 1'b1;
          if (load_cnt_q == IW'(N_BODIES - 1)) begin
            load_cnt_d = '0;
            pass_d     = '0;
            unload_k_d = '0;
            state_d    = ST_FILL;
          end else begin
            load_cnt_d = load_cnt_q + IW'(1);
          end
        end
      end
      ST_FILL: begin
        chain_pos[0]  = body_buf_q[fill_idx].q;
        chain_mass[0] = body_buf_q[fill_idx].m;
        if (unload_k_q == KW'(LANES - 1)) begin
          load_res     = 1'b1;
          clr_acc      = 1'b1;
          unload_k_d   = '0;
          stream_cnt_d = SW'(STREAM_LAST);
          state_d      = ST_STREAM;
        end else begin
          unload_k_d = unload_k_q + KW'(1);
        end
      end
      ST_STREAM: begin
        if (stream_idx < N_BODIES) begin
          chain_pos[0]  = body_buf_q[stream_idx].q;
          chain_mass[0] = body_buf_q[stream_idx].m;
          chain_vld[0]  = body_buf_q[stream_idx].valid;
        end
        if (stream_cnt_q == '0) begin
          state_d     = ST_UNLOAD;
          out_valid_d = 1'b1;
          out_f_d     = acc_w[0];
          out_idx_d   = IW'(int'(pass_q) * LANES);
          out_last_d  = (int'(pass_q) * LANES == N_BODIES - 1);
        end else begin
          stream_cnt_d = stream_cnt_q - SW'(1);
        end
      end
      ST_UNLOAD: begin
        if (out_ready) begin
          if (unload_k_q == KW'(LANES - 1)) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            unload_k_d  = '0;
            if (pass_q == PW'(NPASS - 1)) begin
              pass_d  = '0;
              state_d = ST_LOAD;
            end else begin
              pass_d  = pass_q + PW'(1);
              state_d = ST_FILL;
            end
          end else begin
            unload_k_d = unload_k_q + KW'(1);
            out_f_d    = acc_w[int'(unload_k_q) + 1];
            out_idx_d  = out_idx_q + IW'(1);
            out_last_d = (out_idx_q == IW'(N_BODIES - 2));
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      load_cnt_q   <= '0;
      pass_q       <= '0;
      stream_cnt_q <= '0;
      unload_k_q   <= '0;
      out_valid_q  <= 1'b0;
      out_f_q      <= 0.0;
      out_idx_q    <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      pass_q       <= pass_d;
      stream_cnt_q <= stream_cnt_d;
      unload_k_q   <= unload_k_d;
      out_valid_q  <= out_valid_d;
      out_f_q      <= out_f_d;
      out_idx_q    <= out_idx_d;
      out_last_q   <= out_last_d;
    end
  end

  // Buffer is not reset; every entry is rewritten by the next load.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      body_buf_q[load_cnt_q].q     <= in_q;
      body_buf_q[load_cnt_q].m     <= in_m;
      body_buf_q[load_cnt_q].valid <= 1'b1;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    if (k < LANES - 1) begin : g_mid
      systolic_n_body_lane_cell u_cell (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_res     (load_res),
        .clr_acc      (clr_acc),
        .in_body_pos  (chain_pos[k]),
        .in_body_mass (chain_mass[k]),
        .in_body_vld  (chain_vld[k]),
        .out_body_pos (chain_pos[k+1]),
        .out_body_mass(chain_mass[k+1]),
        .out_body_vld (chain_vld[k+1]),
        .acc          (acc_w[k])
      );
    end else begin : g_tail
      systolic_n_body_lane_cell u_cell (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_res     (load_res),
        .clr_acc      (clr_acc),
        .in_body_pos  (chain_pos[k]),
        .in_body_mass (chain_mass[k]),
        .in_body_vld  (chain_vld[k]),
        .out_body_pos (tail_pos_unused),
        .out_body_mass(tail_mass_unused),
        .out_body_vld (tail_vld_unused),
        .acc          (acc_w[k])
      );
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_LOAD);
  assign out_valid = out_valid_q;
  assign out_f     = out_f_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_systolic_n_body_linear.sv
module tb_systolic_n_body_linear;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_busy;
  real        a_in_q, a_in_m, a_out_f;
  logic [1:0] a_out_idx;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
  real        b_in_q, b_in_m, b_out_f;
  logic [2:0] b_out_idx;

  systolic_n_body_linear #(.N_BODIES(4), .LANES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_q(a_in_q), .in_m(a_in_m),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_f(a_out_f),
    .out_idx(a_out_idx), .out_last(a_out_last), .busy(a_busy)
  );

  systolic_n_body_linear #(.N_BODIES(8), .LANES(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_q(b_in_q), .in_m(b_in_m),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_f(b_out_f),
    .out_idx(b_out_idx), .out_last(b_out_last), .busy(b_busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  real  tq [8];
  real  tm [8];
  real  exp_f [8];

  real  got_f [8];
  int   got_idx [8];
  logic got_last [8];
  int   got_n, first_vld_cyc, rdy_cyc, last_xfer_cyc, stall_bad;
  logic rdy_out_valid;
  logic prev_stall, plast;
  real  pf;
  logic [1:0] pidx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_r(input string tag, input real obs, input real exp);
    n_assert++;
    assert ((obs - exp < 1e-9) && (exp - obs < 1e-9)) else begin
      n_fail++;
      $error("FAIL %s: observed %.12f expected %.12f", tag, obs, exp);
    end
  endtask

  function automatic real model_force(input int i, input int n);
    real s, d, ad;
    s = 0.0;
    for (int j = 0; j < n; j++) begin
      d  = tq[j] - tq[i];
      ad = (d < 0.0) ? -d : d;
      if (ad >= 1e-8) s = s + tm[i] * tm[j] * d / (ad * ad * ad);
    end
    return s;
  endfunction

  task automatic load_a();
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1;
      a_in_q     = tq[i];
      a_in_m     = tm[i];
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
  endtask

  // Cycle index counts posedges since the last load beat.
  task automatic collect_a(input int pct);
    got_n = 0; first_vld_cyc = -1; rdy_cyc = -1; last_xfer_cyc = -1;
    stall_bad = 0; prev_stall = 1'b0; rdy_out_valid = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (prev_stall && (a_out_valid !== 1'b1 || a_out_f != pf ||
                         a_out_idx !== pidx || a_out_last !== plast))
        stall_bad++;
      if (a_out_valid === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (cyc > 0 && a_in_ready === 1'b1) begin
        rdy_cyc = cyc;
        rdy_out_valid = a_out_valid;
        break;
      end
      a_out_ready = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
      if (a_out_valid === 1'b1 && a_out_ready) begin
        if (got_n < 8) begin
          got_f[got_n]    = a_out_f;
          got_idx[got_n]  = int'(a_out_idx);
          got_last[got_n] = a_out_last;
        end
        got_n++;
        last_xfer_cyc = cyc;
      end
      prev_stall = (a_out_valid === 1'b1) && !a_out_ready;
      pf = a_out_f; pidx = a_out_idx; plast = a_out_last;
      @(posedge clk); #1;
    end
    a_out_ready = 1'b1;
  endtask

  task automatic check_a(input string tag);
    chk({tag, "_beats"}, got_n, 4);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_idx", $sformatf("%0d", i)}, got_idx[i], i);
      chk({tag, "_last", $sformatf("%0d", i)}, {31'd0, got_last[i]}, (i == 3) ? 1 : 0);
      chk_r({tag, "_f", $sformatf("%0d", i)}, got_f[i], exp_f[i]);
    end
    chk({tag, "_stall_stable"}, stall_bad, 0);
    chk({tag, "_ready_back"}, (rdy_cyc >= 0) ? 1 : 0, 1);
  endtask

  task automatic set_even();
    for (int i = 0; i < 4; i++) begin
      tq[i] = real'(i);
      tm[i] = 1.0;
    end
    exp_f[0] = 1.0 + 0.25 + 1.0 / 9.0;
    exp_f[1] = 0.25;
    exp_f[2] = -0.25;
    exp_f[3] = -(1.0 + 0.25 + 1.0 / 9.0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    real sum_f;
    int  b_n, b_first;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_q = 0.0; a_in_m = 0.0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_q = 0.0; b_in_m = 0.0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_last", a_out_last, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_out_idx", a_out_idx, 0);
    chk_r("rst_out_f", a_out_f, 0.0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Evenly spaced, out_ready held high: latency and timestep length
    set_even();
    load_a();
    chk("even_in_ready_drop", a_in_ready, 0);
    chk("even_busy", a_busy, 1);
    collect_a(100);
    check_a("even");
    chk("even_first_valid_cyc", first_vld_cyc, 7);
    chk("even_timestep_cyc", rdy_cyc, 18);
    chk("even_ready_after_last", rdy_cyc, last_xfer_cyc + 1);
    chk("even_valid_low_in_load", rdy_out_valid, 0);

    // Coincident bodies
    for (int i = 0; i < 4; i++) begin
      tq[i] = 5.0; tm[i] = 2.0; exp_f[i] = 0.0;
    end
    load_a();
    collect_a(100);
    check_a("coin");

    // Back-pressure at two ready densities
    set_even();
    load_a();
    collect_a(30);
    check_a("bp30");
    load_a();
    collect_a(70);
    check_a("bp70");

    // Reset while streaming, then reload
    load_a();
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy_before_rst", a_busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_in_ready", a_in_ready, 1);
    chk("mid_rst_out_valid", a_out_valid, 0);
    chk("mid_rst_busy", a_busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_a();
    collect_a(100);
    check_a("after_rst");

    // Larger configuration on the N=8, LANES=4 instance
    tq[0] = 0.0;  tq[1] = 1.0;  tq[2] = 3.0;  tq[3] = 6.0;
    tq[4] = 10.0; tq[5] = 15.0; tq[6] = 21.0; tq[7] = 28.0;
    for (int i = 0; i < 8; i++) tm[i] = real'(i + 1);
    for (int i = 0; i < 8; i++) exp_f[i] = model_force(i, 8);
    chk("big_in_ready", b_in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      b_in_valid = 1'b1; b_in_q = tq[i]; b_in_m = tm[i];
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    b_n = 0; b_first = -1; rdy_cyc = -1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (cyc > 0 && b_in_ready === 1'b1) begin
        rdy_cyc = cyc;
        break;
      end
      if (b_out_valid === 1'b1) begin
        if (b_first < 0) b_first = cyc;
        if (b_n < 8) begin
          got_f[b_n]    = b_out_f;
          got_idx[b_n]  = int'(b_out_idx);
          got_last[b_n] = b_out_last;
        end
        b_n++;
      end
      @(posedge clk); #1;
    end
    chk("big_beats", b_n, 8);
    chk("big_first_valid_cyc", b_first, 15);
    chk("big_timestep_cyc", rdy_cyc, 38);
    sum_f = 0.0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("big_idx%0d", i), got_idx[i], i);
      chk($sformatf("big_last%0d", i), {31'd0, got_last[i]}, (i == 7) ? 1 : 0);
      chk_r($sformatf("big_f%0d", i), got_f[i], exp_f[i]);
      sum_f = sum_f + got_f[i];
    end
    chk_r("big_sum_zero", sum_f, 0.0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
